// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit: the next-PC select
// encoding and the instruction-offset width helper.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_JMP,
        NPC_RET,
        NPC_TRAP,
        NPC_HOLD
    } npc_sel_e;

    // Number of low PC bits that sit inside one instruction (log2 of its size).
    function automatic int ofs_of(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// count, so a push while full silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int PC_W  = 7,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_top_next;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_wr_ptr;
    logic             w_wr_en;
    logic             w_empty;
    logic             w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // Pop-then-push on a non-empty stack collapses to a top overwrite; on an
    // empty stack the pop is a no-op, so it degenerates to a plain push.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_top_next   = r_top;
        w_count_next = r_count;
        w_wr_ptr     = r_top;
        w_wr_en      = 1'b0;
        if (i_push && i_pop && !w_empty) begin
            w_wr_en  = 1'b1;
            w_wr_ptr = r_top;
        end else if (i_push) begin
            w_top_next = r_top + PTR_W'(1);
            w_wr_ptr   = r_top + PTR_W'(1);
            w_wr_en    = 1'b1;
            if (!w_full) begin
                w_count_next = r_count + CNT_W'(1);
            end
        end else if (i_pop && !w_empty) begin
            w_top_next   = r_top - PTR_W'(1);
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else begin
            r_top   <= w_top_next;
            r_count <= w_count_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= i_data;
        end
    end

    assign o_top   = r_mem[r_top];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection, PC and misalign registers.
// Optional return-address stack is built when the macro PC_RAS_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W        = 7,
    parameter int              INSTR_BYTES = 4,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            trap,
    input  logic [PC_W-1:0] trap_vec,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus,
    output logic            misalign,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int              OFS      = ofs_of(INSTR_BYTES);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'((1 << OFS) - 1);

    if ((INSTR_BYTES < 1) || ((INSTR_BYTES & (INSTR_BYTES - 1)) != 0)) begin : g_bad_instr_bytes
        $error("pc_unit: INSTR_BYTES must be a power of two");
    end
    if ((RESET_VEC & LOW_MASK) != '0) begin : g_bad_reset_vec
        $error("pc_unit: RESET_VEC must be instruction aligned");
    end
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
        $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
    end

    logic [PC_W-1:0] r_pc;
    logic            r_misalign;

    npc_sel_e        w_sel;
    logic [PC_W-1:0] w_pc_plus;
    logic [PC_W-1:0] w_ret_target;
    logic [PC_W-1:0] w_raw_target;
    logic [PC_W-1:0] w_pc_next;
    logic            w_redirect;
    logic            w_misalign_next;

    assign w_pc_plus = r_pc + PC_W'(INSTR_BYTES);

`ifdef PC_RAS_EN
    logic            w_ras_push;
    logic            w_ras_pop;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    // The stack only moves on cycles that actually retire the call/ret.
    assign w_ras_push = call && !stall && !trap;
    assign w_ras_pop  = ret  && !stall && !trap;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_ras_push),
        .i_pop   (w_ras_pop),
        .i_data  (w_pc_plus),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    // A simultaneous call means the popped slot is refilled and we go to the callee.
    assign w_ret_target = (call || w_ras_empty) ? jmp_target : w_ras_top;
    assign ras_empty    = w_ras_empty;
    assign ras_full     = w_ras_full;
`else
    assign w_ret_target = jmp_target;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
`endif

    always_comb begin
        w_sel = NPC_SEQ;
        if (trap) begin
            w_sel = NPC_TRAP;
        end else if (stall) begin
            w_sel = NPC_HOLD;
        end else if (ret) begin
            w_sel = NPC_RET;
        end else if (call || jmp) begin
            w_sel = NPC_JMP;
        end else if (br_taken) begin
            w_sel = NPC_BR;
        end
    end

    // Trap vectors are aligned like any target but never raise misalign.
    always_comb begin
        w_raw_target = jmp_target;
        w_redirect   = 1'b0;
        w_pc_next    = r_pc;
        unique case (w_sel)
            NPC_TRAP: w_pc_next = trap_vec & ~LOW_MASK;
            NPC_HOLD: w_pc_next = r_pc;
            NPC_RET: begin
                w_raw_target = w_ret_target;
                w_redirect   = 1'b1;
            end
            NPC_JMP: begin
                w_raw_target = jmp_target;
                w_redirect   = 1'b1;
            end
            NPC_BR: begin
                w_raw_target = br_target;
                w_redirect   = 1'b1;
            end
            NPC_SEQ:  w_pc_next = w_pc_plus;
            default:  w_pc_next = r_pc;
        endcase
        if (w_redirect) begin
            w_pc_next = w_raw_target & ~LOW_MASK;
        end
    end

    assign w_misalign_next = w_redirect && ((w_raw_target & LOW_MASK) != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc_out   = r_pc;
    assign pc_plus  = w_pc_plus;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver predicts each cycle's outputs from a
// queue-based behavioural model, and a monitor compares them after every edge.
module tb_pc_unit;

    localparam int PC_W  = 7;
    localparam int IB    = 4;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << PC_W;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            stall = 1'b0;
    logic            br_taken = 1'b0;
    logic [PC_W-1:0] br_target = '0;
    logic            jmp = 1'b0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [PC_W-1:0] jmp_target = '0;
    logic            trap = 1'b0;
    logic [PC_W-1:0] trap_vec = '0;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] pc_plus;
    logic            misalign;
    logic            ras_empty;
    logic            ras_full;

    pc_unit #(
        .PC_W        (PC_W),
        .INSTR_BYTES (IB),
        .RESET_VEC   (7'd0),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .call       (call),
        .ret        (ret),
        .jmp_target (jmp_target),
        .trap       (trap),
        .trap_vec   (trap_vec),
        .pc_out     (pc_out),
        .pc_plus    (pc_plus),
        .misalign   (misalign),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit mis;
        bit empty;
        bit full;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state: architectural PC, misalign flag, and the return
    // stack as a plain list with the newest address at the back.
    int   m_pc = 0;
    bit   m_mis = 1'b0;
    int   m_ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int align(input int v);
        return v & ~(IB - 1);
    endfunction

    task automatic ras_push(input int v);
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(v);
    endtask

    task automatic apply(input bit t, input bit s, input bit r, input bit c, input bit j,
                         input bit b, input int bt, input int jt, input int tv);
        int  plus;
        int  target;
        bit  redirect;
        @(negedge clk);
        trap = t; stall = s; ret = r; call = c; jmp = j; br_taken = b;
        br_target = PC_W'(bt); jmp_target = PC_W'(jt); trap_vec = PC_W'(tv);
        plus = (m_pc + IB) % MOD;
        redirect = 1'b0;
        target = 0;
        if (t) begin
            m_pc = align(tv);
            m_mis = 1'b0;
        end else if (s) begin
            m_mis = 1'b0;
        end else if (r) begin
            redirect = 1'b1;
            target = jt;
            if (RAS_EN) begin
                if (c) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                    ras_push(plus);
                end else if (m_ras.size() > 0) begin
                    target = m_ras.pop_back();
                end
            end
        end else if (c || j) begin
            redirect = 1'b1;
            target = jt;
            if (c && RAS_EN) ras_push(plus);
        end else if (b) begin
            redirect = 1'b1;
            target = bt;
        end else begin
            m_pc = plus;
            m_mis = 1'b0;
        end
        if (redirect) begin
            m_mis = (target % IB) != 0;
            m_pc = align(target);
        end
        sb.push_back('{m_pc, m_mis, m_ras.size() == 0, m_ras.size() == DEPTH});
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        trap = 0; stall = 0; ret = 0; call = 0; jmp = 0; br_taken = 0;
        #1;
        check("reset_pc_async", 32'(pc_out), 32'd0);
        check("reset_misalign", 32'(misalign), 32'd0);
        check("reset_ras_empty", 32'(ras_empty), 32'd1);
        check("reset_ras_full", 32'(ras_full), 32'd0);
        sb.delete();
        m_pc = 0;
        m_mis = 1'b0;
        m_ras.delete();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_out", 32'(pc_out), 32'(e.pc));
                check("pc_plus", 32'(pc_plus), 32'((e.pc + IB) % MOD));
                check("misalign", 32'(misalign), 32'(e.mis));
                check("ras_empty", 32'(ras_empty), 32'(e.empty));
                check("ras_full", 32'(ras_full), 32'(e.full));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Free run from reset, then an asynchronous reset mid-run.
        do_reset();
        repeat (3) idle();
        do_reset();

        // Sequential wrap at the top of the address space.
        apply(0, 0, 0, 0, 1, 0, 0, 124, 0);
        idle();
        idle();

        // Misaligned branch target, then jmp beating br_taken.
        apply(0, 0, 0, 0, 0, 1, 'h13, 0, 0);
        idle();
        apply(0, 0, 0, 0, 1, 1, 'h30, 'h20, 0);

        // Nested call/return from PC 8.
        do_reset();
        idle();
        idle();
        apply(0, 0, 0, 1, 0, 0, 0, 'h40, 0);
        apply(0, 0, 0, 1, 0, 0, 0, 'h60, 0);
        apply(0, 0, 1, 0, 0, 0, 0, 'h10, 0);
        apply(0, 0, 1, 0, 0, 0, 0, 'h14, 0);

        // Five pushes into a four-deep stack, drain it, then ret on empty.
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 0, 0, 0, 'h10 * i + 'h8, 0);
        apply(0, 0, 1, 1, 0, 0, 0, 'h50, 0);
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 0, 0, 0, 0, 'h2C, 0);
        apply(0, 0, 1, 0, 0, 0, 0, 'h28, 0);
        apply(0, 0, 1, 1, 0, 0, 0, 'h31, 0);

        // Stall holds despite br_taken; trap overrides stall and leaves the stack alone.
        apply(0, 0, 0, 1, 0, 0, 0, 'h40, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 1, 'h18, 0, 0);
        apply(1, 1, 1, 1, 0, 0, 0, 'h08, 'h7C);
        apply(1, 0, 0, 0, 0, 1, 'h11, 0, 'h35);
        idle();

        // Random mix of controls, with the occasional asynchronous reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                apply($urandom_range(99) < 5, $urandom_range(99) < 15, $urandom_range(99) < 15,
                      $urandom_range(99) < 15, $urandom_range(99) < 10, $urandom_range(99) < 20,
                      int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                      int'($urandom_range(MOD - 1)));
            end
        end

        @(negedge clk);
        trap = 0; stall = 0; ret = 0; call = 0; jmp = 0; br_taken = 0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
